// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_arb_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        F_WAIT = 2'd1,
        D_WAIT = 2'd2
    } state_e;

    typedef enum logic {
        SEL_F = 1'b0,
        SEL_D = 1'b1
    } port_sel_e;

    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return (byte_off != 2'b00);
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the fetch port, the debug/loader port and the instruction RAM.
interface imem_arbiter_if #(
    parameter int ADDR_W = 10
);
    import imem_arb_pkg::*;

    logic              f_req_valid;
    logic              f_req_ready;
    logic [XLEN-1:0]   f_addr;
    logic              f_rsp_valid;
    logic [XLEN-1:0]   f_rdata;
    logic              f_err;

    logic              d_req_valid;
    logic              d_req_ready;
    logic              d_we;
    logic [XLEN-1:0]   d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic              d_rsp_valid;
    logic [XLEN-1:0]   d_rdata;
    logic              d_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;

    modport slave (
        input  f_req_valid, f_addr,
        input  d_req_valid, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output f_req_ready, f_rsp_valid, f_rdata, f_err,
        output d_req_ready, d_rsp_valid, d_rdata, d_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output f_req_valid, f_addr,
        output d_req_valid, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  f_req_ready, f_rsp_valid, f_rdata, f_err,
        input  d_req_ready, d_rsp_valid, d_rdata, d_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_arb_prio.sv
// Grant selection between fetch and debug with a bounded debug burst,
// plus the fetch-starvation counter that enforces the bound.
module imem_arb_prio
    import imem_arb_pkg::*;
#(
    parameter int MAX_DBG_BURST = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      arb_en,
    input  logic      f_valid,
    input  logic      d_valid,
    output logic      gnt_valid,
    output port_sel_e gnt_sel
);

    localparam int               CNT_W   = $clog2(MAX_DBG_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DBG_BURST);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic             starved_s;

    assign starved_s = (count_r == CNT_MAX);

    // Debug wins contention until fetch has waited out a full burst.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_sel   = SEL_F;
        if (arb_en) begin
            if (f_valid && d_valid) begin
                gnt_valid = 1'b1;
                gnt_sel   = starved_s ? SEL_F : SEL_D;
            end else if (d_valid) begin
                gnt_valid = 1'b1;
                gnt_sel   = SEL_D;
            end else if (f_valid) begin
                gnt_valid = 1'b1;
                gnt_sel   = SEL_F;
            end else begin
                gnt_valid = 1'b0;
                gnt_sel   = SEL_F;
            end
        end else begin
            gnt_valid = 1'b0;
            gnt_sel   = SEL_F;
        end
    end

    // Counter next value: clear on fetch grant, count debug grants that bypass a waiting fetch.
    always_comb begin
        count_s = count_r;
        if (gnt_valid && (gnt_sel == SEL_F)) begin
            count_s = {CNT_W{1'b0}};
        end else if (gnt_valid && f_valid && !starved_s) begin
            count_s = count_r + CNT_W'(1);
        end else begin
            count_s = count_r;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_s;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous-read instruction RAM.
// Optional misaligned-address rejection: define IMEM_ARB_MISALIGN_CHECK_EN.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int DEPTH         = 1024,
    parameter int ADDR_W        = $clog2(DEPTH),
    parameter int MAX_DBG_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_arbiter_if.slave bus
);

    state_e            state_r;
    state_e            state_s;
    logic              active_r;
    logic              arb_en_s;
    logic              gnt_valid_s;
    port_sel_e         gnt_sel_s;
    logic [XLEN-1:0]   req_addr_s;
    logic              misalign_s;

    logic              mem_en_r;
    logic              mem_en_s;
    logic              mem_we_r;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [XLEN-1:0]   mem_wdata_r;
    logic [XLEN-1:0]   mem_wdata_s;

    logic              f_rsp_r;
    logic              f_rsp_s;
    logic              d_rsp_r;
    logic              d_rsp_s;
    logic              rsp_rd_r;
    logic              rsp_rd_s;
    logic              f_err_r;
    logic              f_err_s;
    logic              d_err_r;
    logic              d_err_s;

    // active_r holds off grants for the first cycle after reset release,
    // so ready stays low while rst_n is asserted.
    assign arb_en_s = active_r && (state_r == IDLE);

    imem_arb_prio #(
        .MAX_DBG_BURST (MAX_DBG_BURST)
    ) u_prio (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_en    (arb_en_s),
        .f_valid   (bus.f_req_valid),
        .d_valid   (bus.d_req_valid),
        .gnt_valid (gnt_valid_s),
        .gnt_sel   (gnt_sel_s)
    );

    assign req_addr_s = (gnt_sel_s == SEL_D) ? bus.d_addr : bus.f_addr;

`ifdef IMEM_ARB_MISALIGN_CHECK_EN
    assign misalign_s = is_misaligned(req_addr_s[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    // Next state and next values of every registered output.
    always_comb begin
        state_s     = state_r;
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        f_rsp_s     = 1'b0;
        d_rsp_s     = 1'b0;
        rsp_rd_s    = 1'b0;
        f_err_s     = 1'b0;
        d_err_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (gnt_valid_s && misalign_s) begin
                    // Rejected without touching memory; error response next cycle.
                    f_rsp_s = (gnt_sel_s == SEL_F);
                    d_rsp_s = (gnt_sel_s == SEL_D);
                    f_err_s = (gnt_sel_s == SEL_F);
                    d_err_s = (gnt_sel_s == SEL_D);
                    state_s = IDLE;
                end else if (gnt_valid_s) begin
                    mem_en_s   = 1'b1;
                    mem_addr_s = req_addr_s[ADDR_W+1:2];
                    if (gnt_sel_s == SEL_D) begin
                        mem_we_s    = bus.d_we;
                        mem_wdata_s = bus.d_wdata;
                        state_s     = D_WAIT;
                    end else begin
                        mem_we_s    = 1'b0;
                        mem_wdata_s = mem_wdata_r;
                        state_s     = F_WAIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            F_WAIT: begin
                f_rsp_s  = 1'b1;
                rsp_rd_s = 1'b1;
                state_s  = IDLE;
            end
            D_WAIT: begin
                d_rsp_s  = 1'b1;
                rsp_rd_s = !mem_we_r;
                state_s  = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            active_r    <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {XLEN{1'b0}};
            f_rsp_r     <= 1'b0;
            d_rsp_r     <= 1'b0;
            rsp_rd_r    <= 1'b0;
            f_err_r     <= 1'b0;
            d_err_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            active_r    <= 1'b1;
            mem_en_r    <= mem_en_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            f_rsp_r     <= f_rsp_s;
            d_rsp_r     <= d_rsp_s;
            rsp_rd_r    <= rsp_rd_s;
            f_err_r     <= f_err_s;
            d_err_r     <= d_err_s;
        end
    end

    assign bus.f_req_ready = gnt_valid_s && (gnt_sel_s == SEL_F);
    assign bus.d_req_ready = gnt_valid_s && (gnt_sel_s == SEL_D);

    assign bus.mem_en      = mem_en_r;
    assign bus.mem_we      = mem_we_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_wdata   = mem_wdata_r;

    // The RAM presents read data only in the response cycle, so it is steered through there.
    assign bus.f_rsp_valid = f_rsp_r;
    assign bus.f_rdata     = (f_rsp_r && rsp_rd_r) ? bus.mem_rdata : {XLEN{1'b0}};
    assign bus.f_err       = f_err_r;
    assign bus.d_rsp_valid = d_rsp_r;
    assign bus.d_rdata     = (d_rsp_r && rsp_rd_r) ? bus.mem_rdata : {XLEN{1'b0}};
    assign bus.d_err       = d_err_r;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: behavioural reference model plus directed pins.
module tb_imem_arbiter;
    import imem_arb_pkg::*;

    localparam int DEPTH         = 1024;
    localparam int ADDR_W        = 10;
    localparam int MAX_DBG_BURST = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_arbiter_if #(.ADDR_W(ADDR_W)) ifc ();

    imem_arbiter #(
        .DEPTH         (DEPTH),
        .ADDR_W        (ADDR_W),
        .MAX_DBG_BURST (MAX_DBG_BURST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    // Instruction RAM macro: synchronous read, one-cycle latency.
    logic [31:0] ram [DEPTH];
    logic [31:0] ram_q;
    always @(posedge clk) begin
        if (ifc.mem_en) begin
            if (ifc.mem_we) ram[ifc.mem_addr] <= ifc.mem_wdata;
            else            ram_q <= ram[ifc.mem_addr];
        end
    end
    assign ifc.mem_rdata = ram_q;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: serialized accesses, shadow memory, expected events by cycle.
    typedef struct { int cyc; int idx; bit we; logic [31:0] wdata; } mem_exp_t;
    typedef struct { int cyc; bit is_d; logic [31:0] data; bit err; } rsp_exp_t;
    mem_exp_t    mem_q[$];
    rsp_exp_t    rsp_q[$];
    logic [31:0] ref_mem [DEPTH];
    int          cyc_m    = 0;
    int          free_m   = 0;
    int          streak_m = 0;
    bit          act_m    = 1'b0;
    bit          f_acc    = 1'b0;
    bit          d_acc    = 1'b0;

    always @(negedge clk) begin
        bit fv, dv, sel_d, we, misal, exp_fr, exp_dr;
        int idx;
        logic [31:0] a, data;
        if (!rst_n) begin
            chk("rst f_req_ready", ifc.f_req_ready, 32'd0);
            chk("rst d_req_ready", ifc.d_req_ready, 32'd0);
            chk("rst f_rsp_valid", ifc.f_rsp_valid, 32'd0);
            chk("rst d_rsp_valid", ifc.d_rsp_valid, 32'd0);
            chk("rst errs", {30'd0, ifc.f_err, ifc.d_err}, 32'd0);
            chk("rst mem_en/we", {30'd0, ifc.mem_en, ifc.mem_we}, 32'd0);
            chk("rst mem_addr", 32'(ifc.mem_addr), 32'd0);
            chk("rst mem_wdata", ifc.mem_wdata, 32'd0);
            chk("rst f_rdata", ifc.f_rdata, 32'd0);
            chk("rst d_rdata", ifc.d_rdata, 32'd0);
            mem_q.delete();
            rsp_q.delete();
            act_m    = 1'b0;
            streak_m = 0;
            free_m   = 0;
            f_acc    = 1'b0;
            d_acc    = 1'b0;
        end else begin
            if (mem_q.size() > 0 && mem_q[0].cyc == cyc_m) begin
                chk("mem_en", ifc.mem_en, 32'd1);
                chk("mem_we", ifc.mem_we, 32'(mem_q[0].we));
                chk("mem_addr", 32'(ifc.mem_addr), 32'(mem_q[0].idx));
                if (mem_q[0].we) chk("mem_wdata", ifc.mem_wdata, mem_q[0].wdata);
                void'(mem_q.pop_front());
            end else begin
                chk("mem_en idle", ifc.mem_en, 32'd0);
            end
            if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc_m) begin
                chk("f_rsp_valid", ifc.f_rsp_valid, 32'(!rsp_q[0].is_d));
                chk("d_rsp_valid", ifc.d_rsp_valid, 32'(rsp_q[0].is_d));
                if (rsp_q[0].is_d) begin
                    chk("d_rdata", ifc.d_rdata, rsp_q[0].data);
                    chk("d_err", ifc.d_err, 32'(rsp_q[0].err));
                end else begin
                    chk("f_rdata", ifc.f_rdata, rsp_q[0].data);
                    chk("f_err", ifc.f_err, 32'(rsp_q[0].err));
                end
                void'(rsp_q.pop_front());
            end else begin
                chk("rsp idle", {30'd0, ifc.f_rsp_valid, ifc.d_rsp_valid}, 32'd0);
            end

            exp_fr = 1'b0;
            exp_dr = 1'b0;
            if (act_m && cyc_m >= free_m) begin
                fv = ifc.f_req_valid;
                dv = ifc.d_req_valid;
                sel_d = dv && !(fv && streak_m == MAX_DBG_BURST);
                if (fv || dv) begin
                    if (sel_d) begin
                        a = ifc.d_addr;
                        if (fv && streak_m < MAX_DBG_BURST) streak_m++;
                    end else begin
                        a = ifc.f_addr;
                        streak_m = 0;
                    end
                    exp_fr = !sel_d;
                    exp_dr = sel_d;
                    idx    = int'((a >> 2) % DEPTH);
                    misal  = 1'b0;
`ifdef IMEM_ARB_MISALIGN_CHECK_EN
                    misal  = ((a % 4) != 0);
`endif
                    if (misal) begin
                        rsp_q.push_back('{cyc_m + 1, sel_d, 32'd0, 1'b1});
                        free_m = cyc_m + 1;
                    end else begin
                        we = sel_d && ifc.d_we;
                        mem_q.push_back('{cyc_m + 1, idx, we, ifc.d_wdata});
                        if (we) begin
                            data = 32'd0;
                            ref_mem[idx] = ifc.d_wdata;
                        end else begin
                            data = ref_mem[idx];
                        end
                        rsp_q.push_back('{cyc_m + 2, sel_d, data, 1'b0});
                        free_m = cyc_m + 2;
                    end
                end
            end
            chk("f_req_ready", ifc.f_req_ready, 32'(exp_fr));
            chk("d_req_ready", ifc.d_req_ready, 32'(exp_dr));
            f_acc = exp_fr;
            d_acc = exp_dr;
            act_m = 1'b1;
        end
        cyc_m++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access from a requester; reports the first-cycle memory strobes and latency.
    task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata, output bit err,
                          output int lat, output bit t1_en, output bit t1_we,
                          output logic [31:0] t1_addr);
        bit got;
        got = 1'b0; rdata = 32'd0; err = 1'b0; lat = 0;
        t1_en = 1'b0; t1_we = 1'b0; t1_addr = 32'd0;
        tick();
        if (is_d) begin
            ifc.d_req_valid = 1'b1; ifc.d_we = we; ifc.d_addr = addr; ifc.d_wdata = wdata;
        end else begin
            ifc.f_req_valid = 1'b1; ifc.f_addr = addr;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = is_d ? ifc.d_req_ready : ifc.f_req_ready;
            tick();
        end
        ifc.d_req_valid = 1'b0;
        ifc.f_req_valid = 1'b0;
        chk("grant wait", 32'(got), 32'd1);
        got = 1'b0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(negedge clk);
            if (i == 1) begin
                t1_en = ifc.mem_en; t1_we = ifc.mem_we; t1_addr = 32'(ifc.mem_addr);
            end
            if (is_d ? ifc.d_rsp_valid : ifc.f_rsp_valid) begin
                got   = 1'b1;
                lat   = i;
                rdata = is_d ? ifc.d_rdata : ifc.f_rdata;
                err   = is_d ? ifc.d_err : ifc.f_err;
            end
        end
        chk("response wait", 32'(got), 32'd1);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 63));
        return 32'($urandom_range(0, 8191));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, t1a;
        bit er, t1e, t1w;
        int lat;
        bit ord[$];
        bit exp_ord[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bit rdy[5];
        bit rsp[5];

        ifc.f_req_valid = 1'b0; ifc.f_addr = 32'd0;
        ifc.d_req_valid = 1'b0; ifc.d_we = 1'b0; ifc.d_addr = 32'd0; ifc.d_wdata = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     <= 32'h1000_0000 + 32'(i);
            ref_mem[i]  = 32'h1000_0000 + 32'(i);
        end
        ram[2]     <= 32'h0050_0093;
        ref_mem[2]  = 32'h0050_0093;

        repeat (3) tick();
        rst_n = 1'b1;

        // Fetch word 2: response two cycles after grant.
        access(1'b0, 1'b0, 32'h8, 32'd0, rd, er, lat, t1e, t1w, t1a);
        chk("fetch8 T1 mem_en", 32'(t1e), 32'd1);
        chk("fetch8 T1 mem_addr", t1a, 32'd2);
        chk("fetch8 latency", 32'(lat), 32'd2);
        chk("fetch8 data", rd, 32'h0050_0093);

        // Debug write then fetch back.
        access(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, lat, t1e, t1w, t1a);
        chk("dwr T1 mem_we", 32'(t1w), 32'd1);
        chk("dwr T1 mem_addr", t1a, 32'd4);
        chk("dwr ack data", rd, 32'd0);
        chk("dwr latency", 32'(lat), 32'd2);
        access(1'b0, 1'b0, 32'h10, 32'd0, rd, er, lat, t1e, t1w, t1a);
        chk("fetch after dwr", rd, 32'hDEAD_BEEF);

        // Both ports continuously valid: bounded debug burst.
        tick();
        ifc.f_req_valid = 1'b1; ifc.f_addr = 32'h20;
        ifc.d_req_valid = 1'b1; ifc.d_we = 1'b0; ifc.d_addr = 32'h24;
        for (int i = 0; i < 60 && ord.size() < 10; i++) begin
            @(negedge clk);
            if (ifc.d_req_ready) ord.push_back(1'b1);
            if (ifc.f_req_ready) ord.push_back(1'b0);
            tick();
        end
        ifc.f_req_valid = 1'b0;
        ifc.d_req_valid = 1'b0;
        chk("burst grant count", 32'(ord.size()), 32'd10);
        for (int i = 0; i < 10 && i < ord.size(); i++)
            chk($sformatf("burst grant %0d (1=D)", i), 32'(ord[i]), 32'(exp_ord[i]));

        // Back-to-back fetches: re-grant in the response cycle.
        repeat (3) tick();
        ifc.f_req_valid = 1'b1; ifc.f_addr = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rdy[i] = ifc.f_req_ready;
            rsp[i] = ifc.f_rsp_valid;
            tick();
            ifc.f_addr = 32'h4;
        end
        ifc.f_req_valid = 1'b0;
        chk("b2b ready pattern", {27'd0, rdy[0], rdy[1], rdy[2], rdy[3], rdy[4]}, 32'b10101);
        chk("b2b rsp pattern", {27'd0, rsp[0], rsp[1], rsp[2], rsp[3], rsp[4]}, 32'b00101);

        // Reset during F_WAIT abandons the access.
        repeat (3) tick();
        ifc.f_req_valid = 1'b1; ifc.f_addr = 32'hC;
        @(negedge clk);
        chk("rst-test grant", 32'(ifc.f_req_ready), 32'd1);
        tick();
        ifc.f_req_valid = 1'b0;
        chk("rst-test F_WAIT mem_en", 32'(ifc.mem_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst immediate mem_en", 32'(ifc.mem_en), 32'd0);
        chk("rst immediate mem_addr", 32'(ifc.mem_addr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst no f_rsp", 32'(ifc.f_rsp_valid), 32'd0);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-rst no f_rsp", 32'(ifc.f_rsp_valid), 32'd0);
        access(1'b0, 1'b0, 32'h0, 32'd0, rd, er, lat, t1e, t1w, t1a);
        chk("post-rst fetch0", rd, 32'h1000_0000);

        // Address boundaries: index wrap, byte offset.
        access(1'b0, 1'b0, 32'((DEPTH + 3) * 4), 32'd0, rd, er, lat, t1e, t1w, t1a);
        chk("wrap fetch", rd, 32'h1000_0003);
        chk("wrap mem_addr", t1a, 32'd3);
`ifdef IMEM_ARB_MISALIGN_CHECK_EN
        access(1'b1, 1'b1, 32'h6, 32'h1234_5678, rd, er, lat, t1e, t1w, t1a);
        chk("misal mem_en", 32'(t1e), 32'd0);
        chk("misal d_err", 32'(er), 32'd1);
        chk("misal latency", 32'(lat), 32'd1);
        chk("misal rdata", rd, 32'd0);
        access(1'b0, 1'b0, 32'h4, 32'd0, rd, er, lat, t1e, t1w, t1a);
        chk("misal mem unchanged", rd, 32'h1000_0001);
`else
        access(1'b0, 1'b0, 32'h9, 32'd0, rd, er, lat, t1e, t1w, t1a);
        chk("offset ignored data", rd, 32'h0050_0093);
        chk("offset ignored err", 32'(er), 32'd0);
`endif

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (f_acc || !ifc.f_req_valid) begin
                ifc.f_req_valid = ($urandom_range(0, 2) != 0);
                ifc.f_addr      = rand_addr();
            end else if ($urandom_range(0, 15) == 0) begin
                ifc.f_req_valid = 1'b0;
            end
            if (d_acc || !ifc.d_req_valid) begin
                ifc.d_req_valid = ($urandom_range(0, 2) != 0);
                ifc.d_we        = $urandom_range(0, 1) != 0;
                ifc.d_addr      = rand_addr();
                ifc.d_wdata     = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                ifc.d_req_valid = 1'b0;
            end
        end
        tick();
        ifc.f_req_valid = 1'b0;
        ifc.d_req_valid = 1'b0;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
